// File: rtl/syst_pkg.sv
// Shared definitions for the 3x3 systolic array slice: dimension, index types
// and the element-counter to (row, col) mapping.
package syst_pkg;

  localparam int SYST_N = 3;

  typedef logic [3:0] elem_idx_t;   // 0..8
  typedef logic [1:0] beat_idx_t;   // 0..2
  typedef logic       bank_sel_t;   // bank 0 / bank 1

  function automatic beat_idx_t elem_row(input elem_idx_t e);
    elem_idx_t q;
    q = e / elem_idx_t'(SYST_N);
    return q[1:0];
  endfunction

  function automatic beat_idx_t elem_col(input elem_idx_t e);
    elem_idx_t r;
    r = e % elem_idx_t'(SYST_N);
    return r[1:0];
  endfunction

endpackage

// File: rtl/syst_feeder_bank.sv
// One operand bank: A[3][3] and Bc[3][3] with a single element write port and
// a row/column read port. SYST_FEEDER_TRANSPOSE_EN transposes B on write.
module syst_feeder_bank
  import syst_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              we_i,
  input  beat_idx_t                         row_i,
  input  beat_idx_t                         col_i,
  input  logic [WIDTH-1:0]                  a_i,
  input  logic [WIDTH-1:0]                  b_i,
  input  beat_idx_t                         k_i,
  output logic [0:SYST_N-1][WIDTH-1:0]      a_row_o,
  output logic [0:SYST_N-1][WIDTH-1:0]      b_col_o
);

  logic [WIDTH-1:0] a_q [SYST_N][SYST_N];
  logic [WIDTH-1:0] b_q [SYST_N][SYST_N];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < SYST_N; r++) begin
        for (int c = 0; c < SYST_N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (we_i) begin
      a_q[row_i][col_i] <= a_i;
`ifdef SYST_FEEDER_TRANSPOSE_EN
      b_q[col_i][row_i] <= b_i;
`else
      b_q[row_i][col_i] <= b_i;
`endif
    end
  end

  for (genvar gi = 0; gi < SYST_N; gi++) begin : g_rd
    assign a_row_o[gi] = a_q[k_i][gi];
    assign b_col_o[gi] = b_q[k_i][gi];
  end

endmodule

// File: rtl/syst_feeder.sv
// Ping-pong input stager for the 3x3 systolic array: loads A/B element pairs
// into two banks and issues row k of A / column k of B as three beats.
// Optional build macro: SYST_FEEDER_TRANSPOSE_EN (B streamed row-major).
module syst_feeder
  import syst_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_a,
  input  logic [WIDTH-1:0]             s_b,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [0:SYST_N-1][WIDTH-1:0] a_row,
  output logic [0:SYST_N-1][WIDTH-1:0] b_col,
  output logic                         m_last
);

  logic [1:0] full_q, full_d;
  bank_sel_t  wbank_q, wbank_d;
  bank_sel_t  rbank_q, rbank_d;
  elem_idx_t  e_q, e_d;
  beat_idx_t  k_q, k_d;
  logic       load_fire, issue_fire;

  logic [0:SYST_N-1][WIDTH-1:0] rd_a [2];
  logic [0:SYST_N-1][WIDTH-1:0] rd_b [2];

  // s_ready looks only at registered state, never at m_ready.
  assign s_ready    = rstn & ~full_q[wbank_q];
  assign m_valid    = full_q[rbank_q];
  assign m_last     = m_valid & (k_q == beat_idx_t'(SYST_N - 1));
  assign load_fire  = s_valid & s_ready;
  assign issue_fire = m_valid & m_ready;
  assign a_row      = rd_a[rbank_q];
  assign b_col      = rd_b[rbank_q];

  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    e_d     = e_q;
    k_d     = k_q;
    if (load_fire) begin
      if (e_q == elem_idx_t'(SYST_N * SYST_N - 1)) begin
        e_d             = '0;
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end else begin
        e_d = e_q + elem_idx_t'(1);
      end
    end
    // The loading bank is never full, so it differs from rbank whenever both fire.
    if (issue_fire) begin
      if (k_q == beat_idx_t'(SYST_N - 1)) begin
        k_d             = '0;
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end else begin
        k_d = k_q + beat_idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      e_q     <= '0;
      k_q     <= '0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      e_q     <= e_d;
      k_q     <= k_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    syst_feeder_bank #(.WIDTH(WIDTH)) u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .we_i    (load_fire & (wbank_q == bank_sel_t'(gi))),
      .row_i   (elem_row(e_q)),
      .col_i   (elem_col(e_q)),
      .a_i     (s_a),
      .b_i     (s_b),
      .k_i     (k_q),
      .a_row_o (rd_a[gi]),
      .b_col_o (rd_b[gi])
    );
  end

endmodule

// File: doc/syst_feeder.md
# syst_feeder

Input staging block that sits directly upstream of the 3×3 systolic array. It accepts matrix elements one A/B pair per beat and assembles complete 3×3 operand matrices in one of two ping-pong banks. From each full bank it issues three beats to the array over a valid/ready handshake: row k of A and column k of B, for k = 0, 1, 2. Loading the next matrix pair overlaps issuing the current one.

## Interface
- `WIDTH`, default 8: element width in bits; matches the array's `WIDTH`.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `s_valid`  in  1  an element pair is present on `s_a`/`s_b`.
- `s_ready`  out  1  feeder accepts the pair this cycle.
- `s_a`  in  WIDTH  A element, row-major order.
- `s_b`  in  WIDTH  B element, column-major order (see Configuration).
- `m_valid`  out  1  issue beat available.
- `m_ready`  in  1  array accepts the beat; wired to the array's `in_ready`.
- `a_row`  out  WIDTH×[0:2]  row k of A.
- `b_col`  out  WIDTH×[0:2]  column k of B.
- `m_last`  out  1  high on beat k = 2.

## Operation
- Two banks, 0 and 1. Each bank holds `A[3][3]` and `Bc[3][3]`, where `Bc[k]` is column k of B.
- Per-bank `full` flag. Pointers: `wbank`, `rbank`.
- Counters: element counter `e` (0..8), beat counter `k` (0..2).
- Load side:
  - `s_ready = rstn & !full[wbank]`.
  - On `s_valid & s_ready`: `A[e/3][e%3] <= s_a` and `Bc[e/3][e%3] <= s_b` in bank `wbank`; then `e++`.
  - At `e == 8`: `e <= 0`, `full[wbank] <= 1`, toggle `wbank`.
- Issue side:
  - `m_valid = full[rbank]`.
  - `a_row = A[k]`, `b_col = Bc[k]` of bank `rbank`.
  - `m_last = m_valid & (k == 2)`.
  - On `m_valid & m_ready`: `k++`.
  - At `k == 2`: `k <= 0`, `full[rbank] <= 0`, toggle `rbank`.
- Implicit FSM per bank: EMPTY → FILLING (first element written) → FULL (9th element) → DRAINING (first beat accepted) → EMPTY (third beat accepted).
- Simultaneous events:
  - Completing a fill of one bank and the final drain of the other in the same cycle: both updates apply.
  - A bank freed in cycle t is writable from cycle t+1. `s_ready` never depends combinationally on `m_ready`.
- While `m_valid` is high, `a_row`/`b_col`/`m_last` are stable until the handshake; a full bank is never written.
- Reset, including mid-operation:
  - `e`, `k`, `wbank`, `rbank` and `full` are cleared; all bank contents cleared to 0. Partially loaded or partially issued matrices are discarded.
  - Reset values: `s_ready = 0` while `rstn` is low, 1 on the first cycle after reset; `m_valid = 0`, `m_last = 0`, `a_row = b_col = 0`.
- No arithmetic on data; elements pass through unmodified, WIDTH bits.

## Timing
- 9th element accepted at edge t → `m_valid = 1` from cycle t+1 (fill-to-issue latency 1).
- With `m_ready` held high, beats issue on 3 consecutive cycles.
- Steady state is load-bound: one matrix pair per 9 cycles with `s_valid` held high. `s_ready` is never deasserted as long as the consumer drains within 9 cycles.
- Both banks full → `s_ready = 0` until the first drain completes.
- `m_ready` low stalls `k`; it never drops data.

## Configuration
- `SYST_FEEDER_TRANSPOSE_EN` undefined: `s_b` arrives column-major (`Bc[e/3][e%3] <= s_b`).
- `SYST_FEEDER_TRANSPOSE_EN` defined: `s_b` arrives row-major and is transposed on write (`Bc[e%3][e/3] <= s_b`).
- `s_a` handling, timing and all other behaviour are identical in both builds.

## Structure
- Package `syst_pkg`:
  - `localparam SYST_N = 3`.
  - typedefs for element index (0..8), beat index (0..2) and bank select.
  - The package is shared with the array and result stages.
- Sub-module `syst_feeder_bank`: one bank's A/Bc registers, with a single element write port (row, col, data, we) and a row/column read port indexed by k. It is instantiated twice. Full flags and pointers live in the top module.

## Test plan
- Single matrix: A = 1..9 row-major, B column-major 10..18, `m_ready = 1`, check:
  - beats: `a_row = {1,2,3}`, `b_col = {10,11,12}`; then `{4,5,6}`/`{13,14,15}`; then `{7,8,9}`/`{16,17,18}`.
  - `m_last` high on the third beat only.
  - `m_valid` rises one cycle after the 9th accept.
- Backpressure: `m_ready = 0` for 20 cycles while streaming 27 pairs → `s_ready` drops after 18 accepts. Outputs stay `{1,2,3}`/`{10,11,12}` throughout. Releasing `m_ready` drains both matrices in order, and loading then resumes.
- Overlap: continuous `s_valid` for 4 matrices with `m_ready = 1` → `s_ready` stays high for all 36 cycles; 12 beats issued in load order.
- Reset mid-load after 5 elements, and again mid-issue after beat 1 → `m_valid = 0`, outputs 0. The next 9 elements produce a clean first matrix.
- `SYST_FEEDER_TRANSPOSE_EN` build: B streamed row-major 10..18 → `b_col` beats `{10,13,16}`, `{11,14,17}`, `{12,15,18}`.
